exibe_sequencia: RTL

Sequence-presentation controller for the memory game. On request it reads the stored sequence from the synchronous 16x4 ROM, from address 0 up to a given last index. Each element is lit on the LEDs for a fixed on-time, followed by a fixed dark gap. It then signals completion. The comparison datapath consumes the player's answer; this block shows the player the sequence beforehand and shares the ROM address/data interface with it.

---
 rtl/exibe_pkg.sv | 23 ++
 rtl/contador_tempo.sv | 27 ++
 rtl/exibe_sequencia.sv | 130 +++++++++++++
 3 files changed

// File: rtl/exibe_pkg.sv
// Shared definitions for the sequence-presentation controller: state encodings
// and default on/off durations.
package exibe_pkg;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ACENDE  = 3'd2,
    APAGA   = 3'd3,
    FIM     = 3'd4
  } estado_t;

  localparam int TEMPO_ON_PADRAO  = 1000;
  localparam int TEMPO_OFF_PADRAO = 500;

  // Timer only ever holds duration-1, so clog2 of the larger duration suffices.
  function automatic int largura_tempo(input int on, input int off);
    int maior;
    maior = (on > off) ? on : off;
    largura_tempo = (maior > 1) ? $clog2(maior) : 1;
  endfunction

endpackage

// File: rtl/contador_tempo.sv
// Loadable down-counter used for the lit and dark intervals; holds at zero
// until reloaded.
module contador_tempo #(
  parameter int LARGURA = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               carrega,
  input  logic [LARGURA-1:0] valor,
  output logic               zero
);

  logic [LARGURA-1:0] conta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conta <= '0;
    end else if (carrega) begin
      conta <= valor;
    end else if (conta != '0) begin
      conta <= conta - 1'b1;
    end
  end

  assign zero = (conta == '0);

endmodule

// File: rtl/exibe_sequencia.sv
// Shows the stored ROM sequence (addresses 0..limite) on the LEDs, each element
// lit then followed by a dark gap. Optional abort input: EXIBE_SEQUENCIA_CANCELA_EN.
//
// state   | meaning
// OCIOSO  | idle, waiting for iniciar
// CARREGA | one cycle for the synchronous ROM read of the current index
// ACENDE  | element lit for TEMPO_ON cycles
// APAGA   | dark gap for TEMPO_OFF cycles
// FIM     | pronto pulse, back to idle
module exibe_sequencia
  import exibe_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 4,
  parameter int TEMPO_ON  = TEMPO_ON_PADRAO,
  parameter int TEMPO_OFF = TEMPO_OFF_PADRAO
) (
  input  logic              clock,
  input  logic              reset,
`ifdef EXIBE_SEQUENCIA_CANCELA_EN
  input  logic              cancelar,
`endif
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] leds,
  output logic              exibindo,
  output logic              pronto,
  output logic [2:0]        db_estado
);

  localparam int LT = largura_tempo(TEMPO_ON, TEMPO_OFF);
  localparam logic [LT-1:0] CARGA_ON  = LT'(TEMPO_ON - 1);
  localparam logic [LT-1:0] CARGA_OFF = LT'(TEMPO_OFF - 1);

  estado_t           estado, proximo;
  logic [ADDR_W-1:0] indice, lim_reg;
  logic              tempo_zero, carrega_tempo;
  logic [LT-1:0]     valor_tempo;
  logic              inicia, avanca, cancela;

`ifdef EXIBE_SEQUENCIA_CANCELA_EN
  assign cancela = cancelar && (estado != OCIOSO);
`else
  assign cancela = 1'b0;
`endif

  contador_tempo #(.LARGURA(LT)) u_tempo (
    .clock   (clock),
    .reset   (reset),
    .carrega (carrega_tempo),
    .valor   (valor_tempo),
    .zero    (tempo_zero)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= proximo;
    end
  end

  always_comb begin
    proximo       = estado;
    inicia        = 1'b0;
    avanca        = 1'b0;
    carrega_tempo = 1'b0;
    valor_tempo   = CARGA_ON;
    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          proximo = CARREGA;
          inicia  = 1'b1;
        end
      end
      CARREGA: begin
        proximo       = ACENDE;
        carrega_tempo = 1'b1;
        valor_tempo   = CARGA_ON;
      end
      ACENDE: begin
        if (tempo_zero) begin
          proximo       = APAGA;
          carrega_tempo = 1'b1;
          valor_tempo   = CARGA_OFF;
        end
      end
      APAGA: begin
        if (tempo_zero) begin
          if (indice == lim_reg) begin
            proximo = FIM;
          end else begin
            proximo = CARREGA;
            avanca  = 1'b1;
          end
        end
      end
      FIM:     proximo = OCIOSO;
      default: proximo = OCIOSO;
    endcase
    // Abort wins over every other transition.
    if (cancela) begin
      proximo       = OCIOSO;
      avanca        = 1'b0;
      carrega_tempo = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      indice  <= '0;
      lim_reg <= '0;
    end else if (inicia) begin
      indice  <= '0;
      lim_reg <= limite;
    end else if (avanca) begin
      indice  <= indice + 1'b1;
    end
  end

  // ROM output and state are both registered, so this gating cannot glitch.
  assign leds      = (estado == ACENDE) ? mem_data : '0;
  assign mem_addr  = indice;
  assign exibindo  = (estado != OCIOSO);
  assign pronto    = (estado == FIM);
  assign db_estado = estado;

endmodule
